// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: req/ack word fetch, one-entry skid
// buffer toward decode, and branch redirect that drains an in-flight fetch.
module pc_fetch_unit #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        INC      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  pc
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t               state;
  logic                 skid_valid;
  logic [ADDR_W-1:0]    skid_pc;
  logic [INSTR_W-1:0]   skid_instr;

  logic                 ack_ok_c;
  logic                 consume_c;
  logic                 slot_free_c;
  logic [ADDR_W-1:0]    pc_inc_c;
  logic [ADDR_W-1:0]    br_pc_c;
  logic                 unused_br_lsb;

  assign ack_ok_c      = imem_req & imem_ack;
  assign consume_c     = if_valid & ~stall;
  assign slot_free_c   = ~if_valid | ~stall;
  assign pc_inc_c      = pc + INC_V;
  assign br_pc_c       = {br_target[ADDR_W-1:2], 2'b00};
  assign unused_br_lsb = &{1'b0, br_target[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (br_valid) begin
      // Redirect wins; an unacked fetch must still complete on the bus, so drain it.
      pc         <= br_pc_c;
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      if (imem_req && !imem_ack) begin
        state <= DRAIN;
      end else begin
        imem_req <= 1'b0;
        state    <= REQ;
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        DRAIN: begin
          if (ack_ok_c) begin
            imem_req <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_ok_c) begin
            pc <= pc_inc_c;
            if (slot_free_c) begin
              // Delivered straight to decode; keep streaming at the next address.
              if_valid  <= 1'b1;
              if_pc     <= imem_addr;
              if_instr  <= imem_rdata;
              imem_addr <= pc_inc_c;
            end else begin
              skid_valid <= 1'b1;
              skid_pc    <= imem_addr;
              skid_instr <= imem_rdata;
              imem_req   <= 1'b0;
            end
          end else begin
            if (consume_c) begin
              if_valid   <= skid_valid;
              skid_valid <= 1'b0;
              if (skid_valid) begin
                if_pc    <= skid_pc;
                if_instr <= skid_instr;
              end
            end
            // Issue as soon as the skid entry is empty or leaving this cycle.
            if (!imem_req && (!skid_valid || consume_c)) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
